// File: rtl/prim_factor.sv
// Multi-cycle smallest-divisor unit: trial division by repeated subtraction, busy/ack handshake.
// Optional PRIM_CYCLE_CNT_EN adds a 16-bit saturating busy-cycle counter output.
module prim_factor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   output logic             busy,
   output logic             ack,
   output logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] Q,
   output logic             prime
`ifdef PRIM_CYCLE_CNT_EN
   ,
   output logic [15:0]      cycles
`endif
);

   localparam int unsigned DW = WIDTH + 1;
   localparam int unsigned SW = 2 * (WIDTH + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CHECK = 3'd1;
   localparam logic [2:0] DIV   = 3'd2;
   localparam logic [2:0] NEXT  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [DW-1:0]    d_q, d_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             prime_q, prime_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;

   logic [DW-1:0]    d_plus2;
   logic [SW-1:0]    d_plus2_sq;
   logic             accept;

   assign accept     = (state_q == IDLE) && start;
   assign d_plus2    = d_q + DW'(2);
   // Square at double width so the bound test can never wrap.
   assign d_plus2_sq = SW'(d_plus2) * SW'(d_plus2);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      d_d     = d_q;
      m_d     = m_q;
      n_d     = n_q;
      r_d     = r_q;
      q_d     = q_q;
      prime_d = prime_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = A;
               busy_d  = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            state_d = DONE;
            if (x_q == '0) begin
               r_d     = '0;
               q_d     = '0;
               prime_d = 1'b0;
            end else if (x_q == WIDTH'(1)) begin
               r_d     = WIDTH'(1);
               q_d     = WIDTH'(1);
               prime_d = 1'b0;
            end else if (!x_q[0]) begin
               r_d     = WIDTH'(2);
               q_d     = x_q >> 1;
               prime_d = (x_q == WIDTH'(2));
            end else if (x_q < WIDTH'(9)) begin
               r_d     = x_q;
               q_d     = WIDTH'(1);
               prime_d = 1'b1;
            end else begin
               d_d     = DW'(3);
               m_d     = x_q;
               n_d     = '0;
               state_d = DIV;
            end
         end
         DIV: begin
            if (DW'(m_q) >= d_q) begin
               m_d = m_q - WIDTH'(d_q);
               n_d = n_q + WIDTH'(1);
            end else begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (m_q == '0) begin
               r_d     = WIDTH'(d_q);
               q_d     = n_q;
               prime_d = 1'b0;
               state_d = DONE;
            end else if (d_plus2_sq > SW'(x_q)) begin
               r_d     = x_q;
               q_d     = WIDTH'(1);
               prime_d = 1'b1;
               state_d = DONE;
            end else begin
               d_d     = d_plus2;
               m_d     = x_q;
               n_d     = '0;
               state_d = DIV;
            end
         end
         DONE: begin
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         d_q     <= '0;
         m_q     <= '0;
         n_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         prime_q <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         d_q     <= d_d;
         m_q     <= m_d;
         n_q     <= n_d;
         r_q     <= r_d;
         q_q     <= q_d;
         prime_q <= prime_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
      end
   end

   assign busy  = busy_q;
   assign ack   = ack_q;
   assign R     = r_q;
   assign Q     = q_q;
   assign prime = prime_q;

`ifdef PRIM_CYCLE_CNT_EN
   logic [15:0] cycles_q, cycles_d;

   // Counts every edge seen while busy, including the one that raises ack.
   always_comb begin
      cycles_d = cycles_q;
      if (accept) begin
         cycles_d = '0;
      end else if (busy_q && (cycles_q != 16'hFFFF)) begin
         cycles_d = cycles_q + 16'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cycles_q <= '0;
      end else begin
         cycles_q <= cycles_d;
      end
   end

   assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_prim_factor.sv
// Bench for prim_factor: 8- and 12-bit instances against an arithmetic model plus literal checks.
// Build with PRIM_CYCLE_CNT_EN defined to also cover the cycle counter.
module tb_prim_factor;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        start;
   logic [15:0] a_in;

   logic        busy8, ack8, prime8;
   logic [7:0]  r8, q8;
   logic        busy12, ack12, prime12;
   logic [11:0] r12, q12;
`ifdef PRIM_CYCLE_CNT_EN
   logic [15:0] cyc8, cyc12;
`endif

   always #5 Clk = ~Clk;

   prim_factor #(.WIDTH(8)) u_dut8 (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .A     (a_in[7:0]),
      .busy  (busy8),
      .ack   (ack8),
      .R     (r8),
      .Q     (q8),
      .prime (prime8)
`ifdef PRIM_CYCLE_CNT_EN
      ,
      .cycles(cyc8)
`endif
   );

   prim_factor #(.WIDTH(12)) u_dut12 (
      .Clk   (Clk),
      .Rst   (Rst),
      .start (start),
      .A     (a_in[11:0]),
      .busy  (busy12),
      .ack   (ack12),
      .R     (r12),
      .Q     (q12),
      .prime (prime12)
`ifdef PRIM_CYCLE_CNT_EN
      ,
      .cycles(cyc12)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   int unsigned wid [2] = '{8, 12};
   bit          m_valid = 1'b0;
   bit          m_busy [2];
   bit          m_ack  [2];
   bit          m_p    [2];
   int unsigned m_x    [2];
   int unsigned m_r    [2];
   int unsigned m_q    [2];
   int unsigned m_left [2];
   int unsigned m_cyc  [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Edges from acceptance to ack, from the trial-division cost rule.
   function automatic int unsigned latency(input int unsigned x);
      int unsigned s, d;
      if (x <= 1 || (x % 2) == 0 || x < 9) return 2;
      s = 0;
      d = 3;
      forever begin
         s += x / d + 2;
         if ((x % d) == 0) break;
         if ((d + 2) * (d + 2) > x) break;
         d += 2;
      end
      return 2 + s;
   endfunction

   task automatic factor(input int unsigned x, output int unsigned r, output int unsigned q,
                         output bit p);
      int unsigned d;
      if (x == 0) begin
         r = 0; q = 0; p = 0;
      end else if (x == 1) begin
         r = 1; q = 1; p = 0;
      end else begin
         d = 2;
         while ((x % d) != 0) d++;
         r = d;
         q = x / d;
         p = (d == x);
      end
   endtask

   // Reference model, advanced on each rising edge from the stable inputs.
   always @(posedge Clk) begin
      if (Rst) begin
         m_valid = 1'b1;
         for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_ack[i] = 0; m_p[i] = 0;
            m_r[i] = 0; m_q[i] = 0; m_cyc[i] = 0; m_left[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_ack[i] = 0;
            if (!m_busy[i]) begin
               if (start) begin
                  m_x[i]    = int'(a_in) & ((1 << wid[i]) - 1);
                  m_busy[i] = 1;
                  m_left[i] = latency(m_x[i]);
                  m_cyc[i]  = 0;
               end
            end else begin
               m_left[i]--;
               if (m_cyc[i] < 65535) m_cyc[i]++;
               if (m_left[i] == 0) begin
                  m_busy[i] = 0;
                  m_ack[i]  = 1;
                  factor(m_x[i], m_r[i], m_q[i], m_p[i]);
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model; results only matter while idle.
   always @(negedge Clk) begin
      logic [31:0] a_busy, a_ack, a_r, a_q, a_p, a_cyc;
      if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            a_cyc = 32'd0;
            if (i == 0) begin
               a_busy = {31'd0, busy8}; a_ack = {31'd0, ack8}; a_p = {31'd0, prime8};
               a_r = {24'd0, r8}; a_q = {24'd0, q8};
`ifdef PRIM_CYCLE_CNT_EN
               a_cyc = {16'd0, cyc8};
`endif
            end else begin
               a_busy = {31'd0, busy12}; a_ack = {31'd0, ack12}; a_p = {31'd0, prime12};
               a_r = {20'd0, r12}; a_q = {20'd0, q12};
`ifdef PRIM_CYCLE_CNT_EN
               a_cyc = {16'd0, cyc12};
`endif
            end
            check($sformatf("busy w%0d", wid[i]), a_busy, {31'd0, m_busy[i]});
            check($sformatf("ack w%0d", wid[i]), a_ack, {31'd0, m_ack[i]});
            if (!m_busy[i]) begin
               check($sformatf("R w%0d x=%0d", wid[i], m_x[i]), a_r, m_r[i]);
               check($sformatf("Q w%0d x=%0d", wid[i], m_x[i]), a_q, m_q[i]);
               check($sformatf("prime w%0d x=%0d", wid[i], m_x[i]), a_p, {31'd0, m_p[i]});
            end
`ifdef PRIM_CYCLE_CNT_EN
            check($sformatf("cycles w%0d", wid[i]), a_cyc, m_cyc[i]);
`endif
         end
      end
   end

   // One request pulse; waits for both units to idle, then pins results to literals.
   task automatic run(input logic [15:0] a, input int unsigned r8e, input int unsigned q8e,
                      input bit p8e, input int unsigned r12e, input int unsigned q12e,
                      input bit p12e, output int unsigned lat8, output int unsigned bcnt8);
      int unsigned n;
      bit got8;
      n = 0; got8 = 0; lat8 = 0; bcnt8 = 0;
      @(negedge Clk);
      a_in  = a;
      start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge Clk);
         if (busy8) bcnt8++;
         if (ack8 && !got8) begin
            got8 = 1;
            lat8 = n;
         end
         if (!busy8 && !busy12) break;
         n++;
      end
      check($sformatf("timeout a=%0d", a), {30'd0, busy8, busy12}, 32'd0);
      check($sformatf("ack8 seen a=%0d", a), {31'd0, got8}, 32'd1);
      check($sformatf("lit R8 a=%0d", a), {24'd0, r8}, r8e);
      check($sformatf("lit Q8 a=%0d", a), {24'd0, q8}, q8e);
      check($sformatf("lit prime8 a=%0d", a), {31'd0, prime8}, {31'd0, p8e});
      check($sformatf("lit R12 a=%0d", a), {20'd0, r12}, r12e);
      check($sformatf("lit Q12 a=%0d", a), {20'd0, q12}, q12e);
      check($sformatf("lit prime12 a=%0d", a), {31'd0, prime12}, {31'd0, p12e});
   endtask

   task automatic wait_ack8(input string name);
      bit seen;
      seen = 0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge Clk);
         if (ack8) begin
            seen = 1;
            break;
         end
      end
      check(name, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int unsigned lat, bc;
      Rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Rst = 1'b0;
      check("reset busy8", {31'd0, busy8}, 32'd0);
      check("reset R8", {24'd0, r8}, 32'd0);
      check("reset prime12", {31'd0, prime12}, 32'd0);

      run(16'd31, 31, 1, 1, 31, 1, 1, lat, bc);
      run(16'd91, 7, 13, 0, 7, 13, 0, lat, bc);
      run(16'd2, 2, 1, 1, 2, 1, 1, lat, bc);
      check("latency a=2", lat, 32'd2);
`ifdef PRIM_CYCLE_CNT_EN
      check("lit cycles a=2", {16'd0, cyc8}, 32'd2);
`endif
      run(16'd0, 0, 0, 0, 0, 0, 0, lat, bc);
      check("latency a=0", lat, 32'd2);
      run(16'd1, 1, 1, 0, 1, 1, 0, lat, bc);
      check("latency a=1", lat, 32'd2);

      // Abort a long run with a one-cycle reset.
      @(negedge Clk);
      a_in  = 16'd251;
      start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
      repeat (5) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check("abort busy8", {31'd0, busy8}, 32'd0);
      check("abort R8", {24'd0, r8}, 32'd0);
      check("abort Q12", {20'd0, q12}, 32'd0);
      repeat (40) @(negedge Clk);
      run(16'd9, 3, 3, 0, 3, 3, 0, lat, bc);

      // Held start with A changed mid-run.
      @(negedge Clk);
      a_in  = 16'd15;
      start = 1'b1;
      @(posedge Clk);
      #1 a_in = 16'd49;
      wait_ack8("held first ack");
      check("held R8 first", {24'd0, r8}, 32'd3);
      check("held Q8 first", {24'd0, q8}, 32'd5);
      wait_ack8("held second ack");
      start = 1'b0;
      check("held R8 second", {24'd0, r8}, 32'd7);
      check("held Q12 second", {20'd0, q12}, 32'd7);
      repeat (3) @(negedge Clk);

      run(16'd4087, 13, 19, 0, 61, 67, 0, lat, bc);
      run(16'd4093, 11, 23, 0, 4093, 1, 1, lat, bc);
      run(16'd255, 3, 85, 0, 3, 85, 0, lat, bc);
`ifdef PRIM_CYCLE_CNT_EN
      check("cycles vs busy a=255", {16'd0, cyc8}, bc);
`endif
      repeat (3) @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
